// File: rtl/relu_activation_array.sv
// Multi-channel activation stage: per-frame activation select, OUT_WIDTH saturation,
// two-stage valid/ready pipeline with beat counting and end-of-frame tagging.
module relu_activation_array #(
  parameter int NUM_CH     = 8,
  parameter int IN_WIDTH   = 69,
  parameter int OUT_WIDTH  = 32,
  parameter int FRAME_LEN  = 576,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*IN_WIDTH-1:0]    in_data,
  input  logic [1:0]                    mode,
  input  logic [OUT_WIDTH-2:0]          clip_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*OUT_WIDTH-1:0]   out_data,
  output logic                          out_last,
  output logic                          sat_seen
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int ACC_W = IN_WIDTH + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  function automatic logic signed [ACC_W-1:0] activate(
    input logic signed [IN_WIDTH-1:0] x,
    input logic [1:0]                 md,
    input logic [OUT_WIDTH-2:0]       clip
  );
    logic signed [ACC_W-1:0] xe;
    logic signed [ACC_W-1:0] ce;
    xe = {x[IN_WIDTH-1], x};
    ce = {{(ACC_W-OUT_WIDTH+1){1'b0}}, clip};
    case (md)
      2'b00:   activate = xe;
      2'b01:   activate = xe[ACC_W-1] ? '0 : xe;
      2'b10:   activate = xe[ACC_W-1] ? (xe >>> LEAK_SHIFT) : xe;
      default: activate = xe[ACC_W-1] ? '0 : ((xe > ce) ? ce : xe);
    endcase
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] y);
    if (y > SAT_MAX)      saturate = SAT_MAX[OUT_WIDTH-1:0];
    else if (y < SAT_MIN) saturate = SAT_MIN[OUT_WIDTH-1:0];
    else                  saturate = y[OUT_WIDTH-1:0];
  endfunction

  function automatic logic clamps(input logic signed [ACC_W-1:0] y);
    clamps = (y > SAT_MAX) || (y < SAT_MIN);
  endfunction

  logic [CNT_W-1:0]        beat_idx_q, beat_idx_d;
  logic [1:0]              mode_q, mode_eff;
  logic [OUT_WIDTH-2:0]    clip_q, clip_eff;
  logic                    adv1, adv2, accept, frame_start, beat_last;

  logic                    vld_p1_q, last_p1_q;
  logic signed [ACC_W-1:0] y_p1_q [NUM_CH];
  logic signed [ACC_W-1:0] y_p1_d [NUM_CH];

  logic                    vld_p2_q, last_p2_q, sat_p2_q, sat_p2_d, sat_seen_q;
  logic [NUM_CH*OUT_WIDTH-1:0] data_p2_q, data_p2_d;

  assign adv2        = !vld_p2_q || out_ready;
  assign adv1        = !vld_p1_q || adv2;
  assign in_ready    = adv1;
  assign accept      = in_valid && adv1;
  assign frame_start = (beat_idx_q == '0);
  assign beat_last   = (beat_idx_q == LAST_IDX);
  // Beat 0 of a frame runs with the live config; the rest of the frame uses the latched copy.
  assign mode_eff    = frame_start ? mode : mode_q;
  assign clip_eff    = frame_start ? clip_value : clip_q;

  always_comb begin
    beat_idx_d = beat_idx_q;
    if (accept) beat_idx_d = beat_last ? '0 : beat_idx_q + CNT_W'(1);
  end

  // Stage 1: activation at IN_WIDTH+1 bits
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      y_p1_d[i] = activate(in_data[i*IN_WIDTH +: IN_WIDTH], mode_eff, clip_eff);
    end
  end

  // Stage 2: saturation to OUT_WIDTH
  always_comb begin
    data_p2_d = '0;
    sat_p2_d  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      data_p2_d[i*OUT_WIDTH +: OUT_WIDTH] = saturate(y_p1_q[i]);
      sat_p2_d = sat_p2_d | clamps(y_p1_q[i]);
    end
    sat_p2_d = sat_p2_d & vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx_q <= '0;
      mode_q     <= 2'b01;
      clip_q     <= '0;
      vld_p1_q   <= 1'b0;
      last_p1_q  <= 1'b0;
      vld_p2_q   <= 1'b0;
      last_p2_q  <= 1'b0;
      sat_p2_q   <= 1'b0;
      data_p2_q  <= '0;
      sat_seen_q <= 1'b0;
    end else begin
      beat_idx_q <= beat_idx_d;
      if (accept && frame_start) begin
        mode_q <= mode;
        clip_q <= clip_value;
      end
      if (adv1) begin
        vld_p1_q  <= in_valid;
        last_p1_q <= in_valid && beat_last;
      end
      if (adv2) begin
        vld_p2_q  <= vld_p1_q;
        last_p2_q <= last_p1_q;
        sat_p2_q  <= sat_p2_d;
        data_p2_q <= data_p2_d;
      end
      if (vld_p2_q && sat_p2_q) sat_seen_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1) begin
      for (int i = 0; i < NUM_CH; i++) y_p1_q[i] <= y_p1_d[i];
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_last  = last_p2_q;
  assign sat_seen  = sat_seen_q;

endmodule

// File: tb/tb_relu_activation_array.sv
// Directed bench for relu_activation_array: activation modes, saturation, frame config
// latching, backpressure, last tagging and mid-frame reset.
module tb_relu_activation_array;

  localparam int NC = 4;
  localparam int IW = 69;
  localparam int OW = 32;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, sat_seen;
  logic in_ready4, out_valid4, out_last4, sat_seen4;
  logic [NC*IW-1:0] in_data;
  logic [1:0]       mode;
  logic [OW-2:0]    clip_value;
  logic [NC*OW-1:0] out_data, out_data4;

  int n_chk = 0;
  int n_pass = 0;

  logic [NC*OW-1:0] od_q[$];
  logic             ol_q[$];
  logic [NC*OW-1:0] q4_d[$];
  logic             q4_l[$];

  relu_activation_array #(.NUM_CH(NC), .IN_WIDTH(IW), .OUT_WIDTH(OW), .FRAME_LEN(8), .LEAK_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .clip_value(clip_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .sat_seen(sat_seen));

  relu_activation_array #(.NUM_CH(NC), .IN_WIDTH(IW), .OUT_WIDTH(OW), .FRAME_LEN(4), .LEAK_SHIFT(3)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .mode(mode), .clip_value(clip_value), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_last(out_last4), .sat_seen(sat_seen4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      od_q.push_back(out_data);
      ol_q.push_back(out_last);
    end
    if (!rst && out_valid4 && out_ready) begin
      q4_d.push_back(out_data4);
      q4_l.push_back(out_last4);
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic signed [OW-1:0] ch(input logic [NC*OW-1:0] d, input int i);
    return d[i*OW +: OW];
  endfunction

  task automatic set_ch(input int i, input longint v);
    in_data[i*IW +: IW] = IW'(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    od_q.delete(); ol_q.delete(); q4_d.delete(); q4_l.delete();
  endtask

  task automatic send();
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  initial begin
    logic [NC*OW-1:0] hold;
    bit rdy;
    int k;
    hold = '0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'b01; clip_value = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat_seen", sat_seen, 0);
    check("rst_in_ready", in_ready, 1);

    // ReLU with latency
    do_reset();
    mode = 2'b01;
    set_ch(0, -5); set_ch(1, 7); set_ch(2, 0); set_ch(3, 3);
    in_valid = 1'b1;
    #1 check("t1_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t1_lat_early", out_valid, 0);
    step();
    check("t1_out_valid", out_valid, 1);
    check("t1_ch0", ch(out_data, 0), 0);
    check("t1_ch1", ch(out_data, 1), 7);
    check("t1_ch2", ch(out_data, 2), 0);
    check("t1_ch3", ch(out_data, 3), 3);
    check("t1_sat", sat_seen, 0);

    // Leaky ReLU
    do_reset();
    mode = 2'b10;
    set_ch(0, -1); set_ch(1, -9); set_ch(2, -16); set_ch(3, 40);
    send();
    in_valid = 1'b0;
    idle(3);
    check("t2_count", od_q.size(), 1);
    check("t2_ch0", ch(od_q[0], 0), -1);
    check("t2_ch1", ch(od_q[0], 1), -2);
    check("t2_ch2", ch(od_q[0], 2), -2);
    check("t2_ch3", ch(od_q[0], 3), 40);

    // Clipped ReLU with mid-frame config change
    do_reset();
    mode = 2'b11; clip_value = 31'd6;
    set_ch(0, 3); set_ch(1, 6); set_ch(2, 100); set_ch(3, -4);
    for (int b = 0; b < 9; b++) begin
      if (b == 5) begin
        mode = 2'b00;
        clip_value = 31'd50;
      end
      send();
    end
    in_valid = 1'b0;
    idle(4);
    check("t3_count", od_q.size(), 9);
    check("t3_b0_ch0", ch(od_q[0], 0), 3);
    check("t3_b0_ch1", ch(od_q[0], 1), 6);
    check("t3_b0_ch2", ch(od_q[0], 2), 6);
    check("t3_b0_ch3", ch(od_q[0], 3), 0);
    check("t3_b6_ch2", ch(od_q[6], 2), 6);
    check("t3_b6_ch3", ch(od_q[6], 3), 0);
    check("t3_b6_last", ol_q[6], 0);
    check("t3_b7_last", ol_q[7], 1);
    check("t3_b8_ch2", ch(od_q[8], 2), 100);
    check("t3_b8_ch3", ch(od_q[8], 3), -4);

    // Saturation and sticky flag
    do_reset();
    mode = 2'b00;
    set_ch(0, 64'sd1099511627776); set_ch(1, -64'sd1099511627776); set_ch(2, 5); set_ch(3, -5);
    send();
    in_valid = 1'b0;
    idle(4);
    check("t4_ch0", ch(od_q[0], 0), 2147483647);
    check("t4_ch1", ch(od_q[0], 1), 32'sh80000000);
    check("t4_ch2", ch(od_q[0], 2), 5);
    check("t4_ch3", ch(od_q[0], 3), -5);
    check("t4_sat", sat_seen, 1);
    set_ch(0, 1); set_ch(1, 2); set_ch(2, 3); set_ch(3, 4);
    send();
    in_valid = 1'b0;
    idle(4);
    check("t4_sticky", sat_seen, 1);
    do_reset();
    check("t4_sat_rst", sat_seen, 0);

    // Backpressure: out_ready low in cycles 3..7
    do_reset();
    mode = 2'b00;
    in_data = '0;
    k = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 7);
      set_ch(0, k);
      in_valid = (k < 10);
      #1;
      rdy = in_ready;
      if (cyc == 2) check("t5_full_shift", rdy, 1);
      if (cyc == 3) begin
        check("t5_stall_rdy3", rdy, 0);
        hold = out_data;
      end
      if (cyc == 7) begin
        check("t5_stall_rdy7", rdy, 0);
        check("t5_stall_valid", out_valid, 1);
        check("t5_stall_hold", out_data, hold);
        check("t5_stall_beat", ch(out_data, 0), 1);
      end
      if (cyc == 8) check("t5_resume_rdy", rdy, 1);
      @(posedge clk);
      #1;
      if (rdy && k < 10) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);
    check("t5_count", od_q.size(), 10);
    for (int i = 0; i < 10; i++) check("t5_order", ch(od_q[i], 0), i);

    // Two-beat buffering from empty
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    #1 check("t5_buf0", in_ready, 1);
    step();
    check("t5_buf1", in_ready, 1);
    step();
    check("t5_buf2", in_ready, 0);
    check("t5_buf_valid", out_valid, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("t5_buf_count", od_q.size(), 2);

    // FRAME_LEN=4 last tagging and mid-frame reset
    do_reset();
    mode = 2'b00;
    in_data = '0;
    for (int b = 0; b < 9; b++) begin
      set_ch(0, b);
      send();
    end
    in_valid = 1'b0;
    idle(4);
    check("t6_count", q4_d.size(), 9);
    check("t6_last2", q4_l[2], 0);
    check("t6_last3", q4_l[3], 1);
    check("t6_last4", q4_l[4], 0);
    check("t6_last7", q4_l[7], 1);
    check("t6_last8", q4_l[8], 0);
    check("t6_f8_last7", ol_q[7], 1);
    check("t6_rdy_match", in_ready4, in_ready);
    check("t6_sat4", sat_seen4, 0);
    do_reset();
    for (int b = 0; b < 6; b++) begin
      set_ch(0, b);
      send();
    end
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    check("t6_rst_flush", out_valid4, 0);
    rst = 1'b0;
    q4_d.delete(); q4_l.delete();
    for (int b = 20; b < 24; b++) begin
      set_ch(0, b);
      send();
    end
    in_valid = 1'b0;
    idle(4);
    check("t6_post_count", q4_d.size(), 4);
    check("t6_post_first", ch(q4_d[0], 0), 20);
    check("t6_post_last2", q4_l[2], 0);
    check("t6_post_last3", q4_l[3], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/relu_activation_array.md
# relu_activation_array

Parametrised multi-channel activation stage placed between the convolution accumulators and the pooling layer. Each beat carries NUM_CH signed accumulator values. The block applies a per-frame-selectable activation (bypass, ReLU, leaky ReLU, clipped ReLU) and saturates each result to OUT_WIDTH. It moves data through a 2-stage valid/ready pipeline with backpressure, counts beats per frame and tags the final beat.

## Interface
- NUM_CH, 8, channels per beat
- IN_WIDTH, 69, signed input width per channel
- OUT_WIDTH, 32, signed output width per channel; OUT_WIDTH <= IN_WIDTH
- FRAME_LEN, 576, beats per frame (24x24); must be >= 1
- LEAK_SHIFT, 3, arithmetic right-shift applied to negatives in leaky mode
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts the beat this cycle
- in_data  in  NUM_CH*IN_WIDTH  channel i at [i*IN_WIDTH +: IN_WIDTH], signed
- mode  in  2  00 bypass, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU; sampled at frame start
- clip_value  in  OUT_WIDTH-1  unsigned upper clip for mode 11; sampled with mode
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_CH*OUT_WIDTH  channel i at [i*OUT_WIDTH +: OUT_WIDTH], signed
- out_last  out  1  qualifies out_data; high on beat FRAME_LEN-1 of a frame
- sat_seen  out  1  sticky; set when any channel saturated; cleared only by rst

## Operation
- Accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Beat counter beat_idx runs 0..FRAME_LEN-1 and increments per accept. It wraps to 0 after FRAME_LEN-1. Reset value 0.
- Frame config: on accept with beat_idx==0, mode and clip_value are latched. That beat uses the live values. Later beats use the latched values. Changes to mode or clip_value mid-frame have no effect until the next beat 0. Latched reset values: mode 01, clip 0.
- Stage 1 applies the activation per channel at IN_WIDTH+1 bits signed:
  - 00: y = x
  - 01: y = x<0 ? 0 : x
  - 10: y = x<0 ? x>>>LEAK_SHIFT : x. The shift floors, so -1 maps to -1 and -9 maps to -2 with shift 3.
  - 11: y = x<0 ? 0 : min(x, clip_value)
- Stage 2 saturates y to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and registers the result.
  - Any clamp in a stage-2 load sets sat_seen on the following cycle.
- The last tag = (beat_idx==FRAME_LEN-1) at accept. It travels with its beat through both stages. With FRAME_LEN=1, every beat is last and every beat samples mode.
- Pipeline control, with s1_v and s2_v the stage valid bits:
  - adv2 = !s2_v || out_ready
  - adv1 = !s1_v || adv2
  - in_ready = adv1. This is a combinational path from out_ready; it is allowed.
  - Stage 2 loads from stage 1 when adv2. Then s2_v <= s1_v.
  - Stage 1 loads when adv1. Then s1_v <= in_valid.
- A stalled stage holds its data, last tag and valid bit unchanged. No beat is dropped or duplicated.
- out_valid = s2_v. Once out_valid is high, out_data and out_last stay stable until transfer.
- Reset (at any time, including mid-frame):
  - s1_v, s2_v, out_valid, out_last and sat_seen go to 0; out_data goes to 0.
  - beat_idx goes to 0 and in-flight beats are discarded.
  - The next accepted beat is treated as beat 0.

## Timing
- Latency: 2 cycles. A beat accepted at edge N appears with out_valid at edge N+2 when out_ready stays high.
- Throughput: 1 beat/cycle with continuous out_ready.
- Buffering: 2 beats. With out_ready low, the block accepts 2 more beats, then in_ready goes low in the same cycle that both stages are full.
- Simultaneous accept and transfer on a full pipeline: stages shift, in_ready stays high.
- beat_idx and the latched mode update on the same edge as the accept.
- sat_seen rises one cycle after the saturated beat enters stage 2.
- in_ready is 1 during the cycle after reset.

## Test plan
- Mode 01, out_ready=1, inputs ch0=-5, ch1=7, ch2=0 → out_valid 2 cycles later with ch0=0, ch1=7, ch2=0; sat_seen=0.
- Mode 10, LEAK_SHIFT=3, ch0=-1, ch1=-9, ch2=-16, ch3=40 → -1, -2, -2, 40.
- Mode 11, clip_value=6, inputs 3, 6, 100, -4 → 3, 6, 6, 0. Change mode to 00 at beat 5 → output stays clipped until beat 0 of the next frame.
- Mode 00, OUT_WIDTH=32, ch0=2^40, ch1=-2^40 → 2^31-1 and -2^31; sat_seen=1 and stays 1 until rst.
- Backpressure: stream beats 0..9, holding out_ready low for cycles 3..7 → in_ready drops after 2 buffered beats. Output sequence is exactly 0..9 in order, with data stable while stalled.
- FRAME_LEN=4, 9 beats streamed → out_last on beats 3 and 7. Assert rst after beat 5 is accepted → out_valid=0 next cycle, and the next accepted beat gets out_last on its 4th beat after reset.
